// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates MEM-stage load/store and IF fetch requests onto a
// single byte-wide RAM port, serialising multi-byte accesses byte by byte.
// Optional feature macro: IO_FULL_STALL_EN (holds IO-region store bytes
// while the IO output buffer is full).
module mem_ctrl #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned IF_BYTES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_cancel,
   output logic              if_done,
   output logic [31:0]       if_inst,
   input  logic              mem_req,
   input  logic              mem_wr,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [1:0]        mem_type,
   input  logic [31:0]       mem_wdata,
   output logic              mem_done,
   output logic [31:0]       mem_rdata,
   input  logic [7:0]        ram_din,
   output logic [7:0]        ram_dout,
   output logic [ADDR_W-1:0] ram_a,
   output logic              ram_wr,
   input  logic              io_buffer_full
);

   localparam int unsigned CNT_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state, state_d;
   logic [CNT_W-1:0]    cnt, cnt_d;
   logic [CNT_W-1:0]    len, len_d;
   logic [ADDR_W-1:0]   base, base_d;
   logic [ADDR_W-1:0]   ram_a_d;
   logic [ADDR_W-1:0]   issue_a;
   logic [31:0]         wdata, wdata_d;
   logic [31:0]         buf_q, buf_d;
   logic [31:0]         mem_rdata_d, if_inst_d;
   logic [7:0]          ram_dout_d;
   logic                fetch, fetch_d;
   logic                ram_wr_q, ram_wr_d;
   logic                mem_done_d, if_done_d;
   logic                stall_acc, stall_iss;
   logic [1:0]          wr_lane, cap_lane;

   // Byte address issued next in a write, and the byte lanes in use
   assign issue_a  = base + ADDR_W'(cnt);
   assign wr_lane  = cnt[1:0];
   assign cap_lane = 2'(cnt - CNT_W'(1));

`ifdef IO_FULL_STALL_EN
   assign stall_acc = io_buffer_full && (mem_addr[17:16] == 2'b11);
   assign stall_iss = io_buffer_full && (issue_a[17:16] == 2'b11);
`else
   logic unused_io;
   assign unused_io = io_buffer_full;
   assign stall_acc = 1'b0;
   assign stall_iss = 1'b0;
`endif

   // Write strobe never reaches the RAM while the pipeline is frozen
   assign ram_wr = ram_wr_q & rdy;

   function automatic logic [CNT_W-1:0] type_len(input logic [1:0] t);
      case (t)
         2'b00:   return CNT_W'(1);
         2'b01:   return CNT_W'(2);
         default: return CNT_W'(4);
      endcase
   endfunction

   // State and datapath registers; rdy low freezes everything
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         len       <= '0;
         base      <= '0;
         wdata     <= '0;
         buf_q     <= '0;
         fetch     <= 1'b0;
         ram_a     <= '0;
         ram_dout  <= '0;
         ram_wr_q  <= 1'b0;
         mem_done  <= 1'b0;
         if_done   <= 1'b0;
         mem_rdata <= '0;
         if_inst   <= '0;
      end else if (rdy) begin
         state     <= state_d;
         cnt       <= cnt_d;
         len       <= len_d;
         base      <= base_d;
         wdata     <= wdata_d;
         buf_q     <= buf_d;
         fetch     <= fetch_d;
         ram_a     <= ram_a_d;
         ram_dout  <= ram_dout_d;
         ram_wr_q  <= ram_wr_d;
         mem_done  <= mem_done_d;
         if_done   <= if_done_d;
         mem_rdata <= mem_rdata_d;
         if_inst   <= if_inst_d;
      end
   end

   // Next-state: accept, serialise bytes, assemble reads, pulse done
   always_comb begin
      state_d     = state;
      cnt_d       = cnt;
      len_d       = len;
      base_d      = base;
      wdata_d     = wdata;
      buf_d       = buf_q;
      fetch_d     = fetch;
      ram_a_d     = ram_a;
      ram_dout_d  = ram_dout;
      ram_wr_d    = 1'b0;
      mem_done_d  = 1'b0;
      if_done_d   = 1'b0;
      mem_rdata_d = mem_rdata;
      if_inst_d   = if_inst;

      case (state)
         IDLE: begin
            if (mem_req) begin
               base_d  = mem_addr;
               len_d   = type_len(mem_type);
               wdata_d = mem_wdata;
               fetch_d = 1'b0;
               buf_d   = '0;
               cnt_d   = '0;
               if (mem_wr) begin
                  state_d = WRITE;
                  if (!stall_acc) begin
                     ram_a_d    = mem_addr;
                     ram_dout_d = mem_wdata[7:0];
                     ram_wr_d   = 1'b1;
                     cnt_d      = CNT_W'(1);
                  end
               end else begin
                  state_d = READ;
                  ram_a_d = mem_addr;
               end
            end else if (if_req && !if_cancel) begin
               base_d  = if_addr;
               len_d   = CNT_W'(IF_BYTES);
               fetch_d = 1'b1;
               buf_d   = '0;
               cnt_d   = '0;
               state_d = READ;
               ram_a_d = if_addr;
            end
         end
         READ: begin
            if (fetch && if_cancel) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               if ((cnt + CNT_W'(1)) < len)
                  ram_a_d = base + ADDR_W'(cnt + CNT_W'(1));
               if (cnt != '0)
                  buf_d[{cap_lane, 3'b000} +: 8] = ram_din;
               if (cnt == len) begin
                  state_d = DONE;
                  if (fetch) begin
                     if_inst_d = buf_d;
                     if_done_d = 1'b1;
                  end else begin
                     mem_rdata_d = buf_d;
                     mem_done_d  = 1'b1;
                  end
               end
               cnt_d = cnt + CNT_W'(1);
            end
         end
         WRITE: begin
            if (cnt < len) begin
               if (!stall_iss) begin
                  ram_a_d    = issue_a;
                  ram_dout_d = wdata[{wr_lane, 3'b000} +: 8];
                  ram_wr_d   = 1'b1;
                  cnt_d      = cnt + CNT_W'(1);
               end
            end else begin
               state_d    = DONE;
               mem_done_d = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized self-checking bench for mem_ctrl with a byte RAM
// model and a transaction-level shadow memory as reference.
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst, rdy;
   logic        if_req, if_cancel, if_done;
   logic [31:0] if_addr, if_inst;
   logic        mem_req, mem_wr, mem_done;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  mem_type;
   logic [7:0]  ram_din, ram_dout;
   logic [31:0] ram_a;
   logic        ram_wr, io_buffer_full;

   int n_checks = 0;
   int n_fail   = 0;
   int wr_cnt   = 0;
   logic [31:0] last_wa;
   logic [7:0]  last_wd;

   logic [7:0] ram_mem [logic [31:0]];
   logic [7:0] ref_mem [logic [31:0]];

   mem_ctrl #(.ADDR_W(32), .IF_BYTES(4)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
      .if_done(if_done), .if_inst(if_inst),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_type(mem_type), .mem_wdata(mem_wdata),
      .mem_done(mem_done), .mem_rdata(mem_rdata),
      .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a),
      .ram_wr(ram_wr), .io_buffer_full(io_buffer_full)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
   endfunction

   // Byte RAM: one-edge read latency, write on strobe
   always @(posedge clk) begin
      if (ram_wr) begin
         ram_mem[ram_a] = ram_dout;
         wr_cnt  = wr_cnt + 1;
         last_wa = ram_a;
         last_wd = ram_dout;
      end
      ram_din <= ram_mem.exists(ram_a) ? ram_mem[ram_a] : init_byte(ram_a);
   end

   function automatic logic [7:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
      logic [31:0] v;
      v = '0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = ref_rd(a + 32'(k));
      return v;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One load/store; g>=0 drops rdy for 2 edges after g edges, io>0 holds io_buffer_full for io edges
   task automatic run_mem(input bit wr, input logic [31:0] a, input logic [1:0] t,
                          input logic [31:0] wd, input int g, input int io);
      int n, lat, exp_lat, w0;
      bit seen;
      n  = (t == 2'b00) ? 1 : (t == 2'b01) ? 2 : 4;
      w0 = wr_cnt;
      exp_lat = (wr ? n + 1 : n + 2) + ((g >= 0) ? 2 : 0);
`ifdef IO_FULL_STALL_EN
      if (wr && a[17:16] == 2'b11) exp_lat += io;
`endif
      mem_req = 1'b1; mem_wr = wr; mem_addr = a; mem_type = t; mem_wdata = wd;
      if (io > 0) io_buffer_full = 1'b1;
      lat = 0;
      seen = 1'b0;
      do begin
         if (g >= 0 && lat == g) rdy = 1'b0;
         if (g >= 0 && lat == g + 2) rdy = 1'b1;
         if (io > 0 && lat == io) io_buffer_full = 1'b0;
         tick();
         lat++;
         seen = mem_done;
      end while (!seen && lat < 40);
      rdy = 1'b1;
      io_buffer_full = 1'b0;
      mem_req = 1'b0;
      check("mem_latency", 32'(lat), 32'(exp_lat));
      if (wr) begin
         for (int k = 0; k < n; k++) ref_mem[a + 32'(k)] = wd[8*k +: 8];
         check("mem_write_count", 32'(wr_cnt - w0), 32'(n));
      end else begin
         check("mem_rdata", mem_rdata, ref_load(a, n));
      end
      tick();
      check("mem_done_pulse", {31'b0, mem_done}, 32'h0);
   endtask

   task automatic run_fetch(input logic [31:0] a);
      int lat;
      bit seen;
      if_req = 1'b1; if_addr = a;
      lat = 0;
      seen = 1'b0;
      do begin
         tick();
         lat++;
         seen = if_done;
      end while (!seen && lat < 40);
      if_req = 1'b0;
      check("fetch_latency", 32'(lat), 32'd6);
      check("if_inst", if_inst, ref_load(a, 4));
      tick();
      check("if_done_pulse", {31'b0, if_done}, 32'h0);
   endtask

   initial begin
      int lat;
      bit seen;
      rst = 1'b0; rdy = 1'b1;
      if_req = 1'b0; if_addr = '0; if_cancel = 1'b0;
      mem_req = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_type = '0; mem_wdata = '0;
      io_buffer_full = 1'b0;
      tick(); tick();
      check("rst_mem_done", {31'b0, mem_done}, 32'h0);
      check("rst_if_done", {31'b0, if_done}, 32'h0);
      check("rst_ram_wr", {31'b0, ram_wr}, 32'h0);
      check("rst_ram_a", ram_a, 32'h0);
      check("rst_mem_rdata", mem_rdata, 32'h0);
      rst = 1'b1;
      tick();

      // Word load from preloaded bytes
      for (int k = 0; k < 4; k++) begin
         ram_mem[32'h100 + 32'(k)] = 8'(8'h11 * (k + 1));
         ref_mem[32'h100 + 32'(k)] = 8'(8'h11 * (k + 1));
      end
      run_mem(1'b0, 32'h100, 2'b10, 32'h0, -1, 0);
      check("word_load_value", mem_rdata, 32'h44332211);

      // Byte store: one strobe, low data byte
      run_mem(1'b1, 32'h200, 2'b00, 32'hAABBCCDD, -1, 0);
      check("byte_store_addr", last_wa, 32'h200);
      check("byte_store_data", {24'b0, last_wd}, 32'hDD);
      run_mem(1'b0, 32'h200, 2'b10, 32'h0, -1, 0);

      // Simultaneous requests: load first, fetch right after
      mem_req = 1'b1; mem_wr = 1'b0; mem_addr = 32'h100; mem_type = 2'b10;
      if_req = 1'b1; if_addr = 32'h104;
      lat = 0; seen = 1'b0;
      do begin tick(); lat++; seen = mem_done; end while (!seen && lat < 40);
      mem_req = 1'b0;
      check("arb_mem_latency", 32'(lat), 32'd6);
      check("arb_mem_rdata", mem_rdata, 32'h44332211);
      check("arb_no_if_done", {31'b0, if_done}, 32'h0);
      lat = 0; seen = 1'b0;
      do begin tick(); lat++; seen = if_done; end while (!seen && lat < 40);
      if_req = 1'b0;
      check("arb_fetch_latency", 32'(lat), 32'd7);
      check("arb_if_inst", if_inst, ref_load(32'h104, 4));
      tick();

      // Fetch cancelled at E2, then a fresh fetch
      if_req = 1'b1; if_addr = 32'h0;
      tick(); tick();
      if_cancel = 1'b1;
      tick();
      if_cancel = 1'b0; if_req = 1'b0;
      check("cancel_ram_wr", {31'b0, ram_wr}, 32'h0);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         seen |= if_done;
         tick();
      end
      check("cancel_no_done", {31'b0, seen}, 32'h0);
      run_fetch(32'h40);

      // Address wrap on a half load and a word store
      run_mem(1'b0, 32'hFFFF_FFFF, 2'b01, 32'h0, -1, 0);
      run_mem(1'b1, 32'hFFFF_FFFE, 2'b10, 32'hCAFEF00D, -1, 0);
      run_mem(1'b0, 32'h0000_0000, 2'b01, 32'h0, -1, 0);
      check("wrap_low_half", mem_rdata, 32'h0000CAFE);

      // rdy freezes a store mid-way and an idle accept
      run_mem(1'b1, 32'h300, 2'b10, 32'h01020304, 1, 0);
      run_mem(1'b0, 32'h300, 2'b10, 32'h0, 0, 0);
      check("rdy_store_value", mem_rdata, 32'h01020304);

      // IO-region store with buffer full for 3 edges
      run_mem(1'b1, 32'h0003_0000, 2'b10, 32'h89ABCDEF, -1, 3);
      run_mem(1'b0, 32'h0003_0000, 2'b10, 32'h0, -1, 0);
      check("io_store_value", mem_rdata, 32'h89ABCDEF);

      // Reset during a read: outputs cleared, no done afterwards
      mem_req = 1'b1; mem_wr = 1'b0; mem_addr = 32'h1010; mem_type = 2'b10;
      tick(); tick(); tick();
      rst = 1'b0;
      tick();
      mem_req = 1'b0;
      check("rstmid_mem_rdata", mem_rdata, 32'h0);
      check("rstmid_if_inst", if_inst, 32'h0);
      check("rstmid_ram_a", ram_a, 32'h0);
      check("rstmid_outs", {28'b0, mem_done, if_done, ram_wr, |ram_dout}, 32'h0);
      rst = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         seen |= mem_done | if_done;
      end
      check("rstmid_no_done", {31'b0, seen}, 32'h0);

      // Randomized mix of loads, stores and fetches
      for (int i = 0; i < 90; i++) begin
         int op, g;
         logic [31:0] a;
         op = int'($urandom_range(0, 2));
         if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
         else a = 32'h1000 + 32'($urandom_range(0, 31));
         g = -1;
         if ($urandom_range(0, 3) == 0) g = (op == 1) ? 1 : 0;
         case (op)
            0: run_mem(1'b0, a, 2'($urandom_range(0, 3)), 32'h0, g, 0);
            1: run_mem(1'b1, a, 2'($urandom_range(0, 3)), $urandom, g, 0);
            default: run_fetch(a);
         endcase
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
